// File: rtl/lfsr_pkg.sv
// Shared FSM type, default feedback polynomials and the parity helper
// used by the LFSR pseudorandom word generator.
package lfsr_pkg;

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } lfsr_state_e;

    localparam int unsigned MAX_WIDTH = 32;

    // x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'h01;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_16 = 16'h0001;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [31:0] SEED_32 = 32'h0000_0001;

    function automatic logic parity(input logic [MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci shift register: parity of the tapped bits shifts in at bit 0.
// Synchronous load takes priority over shifting.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_8)
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             i_shift,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_sr,
    output logic             o_fb
);

    logic [WIDTH-1:0] r_sr;

    assign o_fb = parity(MAX_WIDTH'(r_sr & TAPS));
    assign o_sr = r_sr;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_sr <= SEED;
        end else if (i_load) begin
            r_sr <= i_load_val;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], o_fb};
        end
    end

endmodule

// File: rtl/lfsr_prng.sv
// LFSR word generator: packs OUT_BITS fresh bits per word onto a valid/ready
// port, handles seed reload with zero-seed substitution and measures period.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS_8),
    parameter int unsigned      OUT_BITS = 4,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(SEED_8)
) (
    input  logic                clk,
    input  logic                ar,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic                rnd_valid,
    input  logic                rnd_ready,
    output logic [OUT_BITS-1:0] rnd_data,
    output logic [WIDTH-1:0]    sr,
    output logic                q,
    output logic                lockup,
    output logic                wrap,
    output logic [WIDTH-1:0]    period
);

    localparam int unsigned      CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);
    localparam logic [WIDTH-1:0] PCNT_MAX = '1;

    lfsr_state_e      r_state;
    lfsr_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_shift;

    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_lockup;
    logic             r_wrap;

    logic [WIDTH-1:0] w_sr;
    logic             w_fb;
    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrap_hit;

    // A zero seed would lock the register; substitute the reset seed.
    assign w_seed_zero  = (seed_in == '0);
    assign w_load_val   = w_seed_zero ? SEED : seed_in;
    assign w_sr_shifted = {w_sr[WIDTH-2:0], w_fb};
    assign w_wrap_hit   = w_shift && (w_sr_shifted == r_seed);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .ar         (ar),
        .i_shift    (w_shift),
        .i_load     (seed_load),
        .i_load_val (w_load_val),
        .o_sr       (w_sr),
        .o_fb       (w_fb)
    );

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Seed reload overrides everything, including a same-cycle handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        case (r_state)
            FILL: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESENT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (rnd_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
            end
        endcase
        if (seed_load) begin
            w_shift     = 1'b0;
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
            r_period <= '0;
            r_pcnt   <= '0;
            r_seed   <= SEED;
        end else begin
            r_valid  <= (w_state_nxt == PRESENT);
            r_lockup <= seed_load && w_seed_zero;
            r_wrap   <= w_wrap_hit;
            if (seed_load) begin
                r_seed <= w_load_val;
                r_pcnt <= '0;
            end else if (w_wrap_hit) begin
                r_period <= r_pcnt + WIDTH'(1);
                r_pcnt   <= '0;
            end else if (w_shift && (r_pcnt != PCNT_MAX)) begin
                r_pcnt <= r_pcnt + WIDTH'(1);
            end
        end
    end

    assign rnd_valid = r_valid;
    assign rnd_data  = w_sr[OUT_BITS-1:0];
    assign sr        = w_sr;
    assign q         = w_sr[WIDTH-1];
    assign lockup    = r_lockup;
    assign wrap      = r_wrap;
    assign period    = r_period;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng at default parameters (8-bit, taps 0xB8,
// 4-bit words): expected words are queued by the stimulus, popped on handshake.
module tb_lfsr_prng;

    logic       clk;
    logic       ar;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       rnd_valid;
    logic       rnd_ready;
    logic [3:0] rnd_data;
    logic [7:0] sr;
    logic       q;
    logic       lockup;
    logic       wrap;
    logic [7:0] period;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [11:0] sb_q[$];
    logic [11:0] mon_exp;
    logic [7:0]  model_s;

    lfsr_prng dut (
        .clk       (clk),
        .ar        (ar),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_data  (rnd_data),
        .sr        (sr),
        .q         (q),
        .lockup    (lockup),
        .wrap      (wrap),
        .period    (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, input string nm);
        int n = 0;
        while (rnd_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(nm, 32'(rnd_valid), 32'd1);
    endtask

    task automatic wait_empty(input int max_cyc, input string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(nm, 32'(sb_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ar && rnd_valid && rnd_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got word 0x%0h with no expected entry", {rnd_data, sr});
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_word", 32'({rnd_data, sr}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ar        = 1'b1;
        seed_load = 1'b0;
        seed_in   = 8'h00;
        rnd_ready = 1'b0;
        #1 ar = 1'b0;
        repeat (2) tick();
        chk("rst_sr",     32'(sr),        32'h01);
        chk("rst_valid",  32'(rnd_valid), 32'd0);
        chk("rst_period", 32'(period),    32'd0);
        chk("rst_lockup", 32'(lockup),    32'd0);
        chk("rst_wrap",   32'(wrap),      32'd0);
        chk("rst_q",      32'(q),         32'd0);

        // Free words after reset: valid one cycle in five
        ar        = 1'b1;
        rnd_ready = 1'b1;
        sb_q.push_back({4'h1, 8'h11});
        sb_q.push_back({4'hC, 8'h1C});
        sb_q.push_back({4'h4, 8'hC4});
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t1_valid_pattern", 32'(rnd_valid), 32'((k % 5) == 4));
        end
        rnd_ready = 1'b0;
        chk("t1_drained", 32'(sb_q.size()), 32'd0);

        // Back-pressure: word and register frozen while not ready
        wait_valid(10, "t2_valid_rise");
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t2_stall_hold", 32'({rnd_valid, rnd_data, sr}), 32'({1'b1, 4'hB, 8'h4B}));
        end
        sb_q.push_back({4'hB, 8'h4B});
        rnd_ready = 1'b1;
        wait_empty(5, "t2_accept");
        chk("t2_valid_fall", 32'(rnd_valid), 32'd0);
        rnd_ready = 1'b0;

        // Zero seed is replaced by 0x01; pending word is dropped
        wait_valid(10, "t3_pending_word");
        seed_in   = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("t3_sr_subst",   32'(sr),        32'h01);
        chk("t3_lockup_on",  32'(lockup),    32'd1);
        chk("t3_word_drop",  32'(rnd_valid), 32'd0);
        tick();
        chk("t3_lockup_off", 32'(lockup),    32'd0);
        sb_q.push_back({4'h1, 8'h11});
        rnd_ready = 1'b1;
        wait_empty(10, "t3_first_word");
        rnd_ready = 1'b0;

        // Full-period free run from 0x01: wraps at shifts 255 and 510
        seed_in   = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        rnd_ready = 1'b1;
        model_s = 8'h01;
        for (int w = 0; w < 128; w++) begin
            repeat (4) model_s = ref_step(model_s);
            sb_q.push_back({model_s[3:0], model_s});
        end
        for (int e = 1; e <= 640; e++) begin
            tick();
            chk("t4_wrap", 32'(wrap), 32'((e == 318) || (e == 637)));
            if (e == 317) chk("t4_period_pre", 32'(period), 32'd0);
            if ((e == 318) || (e == 637)) chk("t4_period", 32'(period), 32'd255);
        end
        rnd_ready = 1'b0;
        chk("t4_drained", 32'(sb_q.size()), 32'd0);

        // Reload in the same cycle as a handshake
        seed_in   = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        repeat (3) tick();
        chk("t5_latency_pre", 32'(rnd_valid), 32'd0);
        tick();
        chk("t5_latency",     32'(rnd_valid), 32'd1);
        chk("t5_word",        32'({rnd_data, sr}), 32'({4'h1, 8'h11}));
        sb_q.push_back({4'h1, 8'h11});
        rnd_ready = 1'b1;
        seed_in   = 8'hA5;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("t5_valid_drop", 32'(rnd_valid),    32'd0);
        chk("t5_sr_loaded",  32'(sr),           32'hA5);
        chk("t5_no_lockup",  32'(lockup),       32'd0);
        chk("t5_accepted",   32'(sb_q.size()),  32'd0);
        sb_q.push_back({4'h4, 8'h54});
        wait_empty(10, "t5_new_seq");
        rnd_ready = 1'b0;

        // Asynchronous reset in the middle of a fill
        seed_in   = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        tick();
        chk("t6_mid_fill_sr",   32'(sr),     32'h04);
        chk("t6_period_before", 32'(period), 32'd255);
        #2 ar = 1'b0;
        #1;
        chk("t6_async_sr",     32'(sr),        32'h01);
        chk("t6_async_data",   32'(rnd_data),  32'h1);
        chk("t6_async_valid",  32'(rnd_valid), 32'd0);
        chk("t6_async_period", 32'(period),    32'd0);
        chk("t6_async_lockup", 32'(lockup),    32'd0);
        chk("t6_async_wrap",   32'(wrap),      32'd0);
        chk("t6_async_q",      32'(q),         32'd0);
        tick();
        tick();
        ar        = 1'b1;
        rnd_ready = 1'b1;
        sb_q.push_back({4'h1, 8'h11});
        sb_q.push_back({4'hC, 8'h1C});
        wait_empty(15, "t6_restart");
        rnd_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
